// File: rtl/serial_pattern_generator.sv
// Bit-serial pattern transmitter: captures pattern/length/repeat on start and shifts it out MSB-first with a valid qualifier.
// Latency: first bit one clock after start is sampled; done pulses one clock after the last bit. No input backpressure; abort cancels a transmission.
module serial_pattern_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_clamp;
    logic [IDX_W-1:0] last_idx;

    assign len_clamp = (length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length;
    assign last_idx  = IDX_W'(len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        rep_cnt_d = rep_cnt_q;
        rep_d     = rep_q;
        idx_d     = idx_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pat_d     = pattern;
                    len_d     = len_clamp;
                    rep_cnt_d = repeat_cnt;
                    rep_d     = '0;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = IDX_W'(len_clamp - LEN_W'(1));
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    x_d       = pat_q[idx_q];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (rep_cnt_q == '0) begin
                        // Continuous mode: counter is frozen so it can never wrap or expire.
                        idx_d = last_idx;
                    end else if (rep_q + CNT_W'(1) == rep_cnt_q) begin
                        rep_d   = rep_q + CNT_W'(1);
                        state_d = S_DONE;
                    end else begin
                        rep_d = rep_q + CNT_W'(1);
                        idx_d = last_idx;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_cnt_q <= '0;
            rep_q     <= '0;
            idx_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: expected bit streams are built per transaction from pattern/length/repeat rules.
module tb_serial_pattern_generator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [CNT_W-1:0] repeat_cnt;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [3:0]       obs;

    int errors = 0;
    int checks = 0;

    assign obs = {x_valid, x, busy, done};

    always #5 clock = ~clock;

    serial_pattern_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pattern    (pattern),
        .length     (length),
        .repeat_cnt (repeat_cnt),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; length = '0; repeat_cnt = '0;
        #12;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: {x_valid,x,busy,done}=%b expected 0000", obs);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: {x_valid,x,busy,done}=%b expected 0000", obs);
        end
    endtask

    // Starts a finite transaction on the next edge; the expected stream is every
    // repetition of pattern[L-1:0] sent MSB-first, followed by one done cycle.
    task automatic test_txn(input logic [WIDTH-1:0] pat, input int len, input int rep,
                            input bit noisy, input bit abort_in_done, input string name);
        bit         q[$];
        int         eff_len;
        logic [3:0] exp;
        eff_len = (len > WIDTH) ? WIDTH : len;
        for (int r = 0; r < rep; r++)
            for (int i = eff_len - 1; i >= 0; i--)
                q.push_back(pat[i]);

        pattern = pat; length = len[3:0]; repeat_cnt = rep[3:0];
        start = 1'b1; abort = 1'b0;
        step;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL %s start_edge: {x_valid,x,busy,done}=%b expected 0000", name, obs);
        end
        start = 1'b0;
        for (int n = 0; n <= q.size(); n++) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                pattern = 8'($urandom);
                length = 4'($urandom);
                repeat_cnt = 4'($urandom);
            end
            if (n == q.size()) break;
            step;
            exp = {1'b1, q[n], 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s bit%0d: {x_valid,x,busy,done}=%b expected %b", name, n, obs, exp);
            end
        end
        if (abort_in_done) abort = 1'b1;
        step;
        checks++;
        if (obs !== 4'b0011) begin
            errors++;
            $display("FAIL %s done_cycle: {x_valid,x,busy,done}=%b expected 0011", name, obs);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_continuous_abort;
        logic [3:0] exp;
        pattern = 8'h05; length = 4'd4; repeat_cnt = 4'd0; start = 1'b1; abort = 1'b0;
        step;
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step;
            exp = {1'b1, (n % 2 == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL cont bit%0d: {x_valid,x,busy,done}=%b expected %b", n, obs, exp);
            end
        end
        abort = 1'b1; start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step;
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL cont_abort cyc%0d: {x_valid,x,busy,done}=%b expected 0000", n, obs);
            end
        end
        abort = 1'b0; start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step;
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL cont_after_abort cyc%0d: {x_valid,x,busy,done}=%b expected 0000", n, obs);
            end
        end
    endtask

    task automatic test_reset_mid;
        pattern = 8'hFF; length = 4'd8; repeat_cnt = 4'd4; start = 1'b1; abort = 1'b0;
        step;
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step;
            checks++;
            if (obs !== 4'b1110) begin
                errors++;
                $display("FAIL rst_mid bit%0d: {x_valid,x,busy,done}=%b expected 1110", n, obs);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_async: {x_valid,x,busy,done}=%b expected 0000", obs);
        end
        step;
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step;
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid_after cyc%0d: {x_valid,x,busy,done}=%b expected 0000", n, obs);
            end
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 25; t++) begin
            test_txn(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset;
        test_txn(8'h05, 4, 1, 1'b0, 1'b0, "single_0101");
        test_txn(8'h05, 4, 3, 1'b0, 1'b0, "repeat3");
        test_txn(8'h3C, 0, 2, 1'b0, 1'b0, "len0");
        test_txn(8'hA5, 12, 1, 1'b0, 1'b0, "len12_clamp");
        test_txn(8'h96, 8, 2, 1'b1, 1'b1, "noisy_abort_in_done");
        test_txn(8'h02, 2, 15, 1'b0, 1'b0, "rep_max");
        test_continuous_abort;
        test_txn(8'h0A, 4, 1, 1'b0, 1'b0, "after_abort");
        test_reset_mid;
        test_txn(8'h5A, 7, 2, 1'b0, 1'b0, "after_reset");
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
